// File: rtl/ser5_tx.sv
// Parallel-in/serial-out transmitter, MSB first, one bit per clk; first bit 1 cycle after handshake.
// Backpressure: ready only in IDLE, the last SHIFT cycle (GAP=0) or the last GAP cycle.
module ser5_tx #(
  parameter int WIDTH = 5,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             out,
  output logic             shifting,
  output logic             word_done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [2:0]    GAP_LAST = 3'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [2:0]       gap_cnt;
  logic [WIDTH-1:0] sreg;
  logic             last_bit;
  logic             last_gap;
  logic             accept;

  always_comb begin
    last_bit = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
    last_gap = (GAP > 0) && (state == S_GAP) && (gap_cnt == GAP_LAST);
    ready    = (state == S_IDLE) || (last_bit && (GAP == 0)) || last_gap;
    accept   = valid && ready && !clear;
  end

  // sreg holds the bits still to be sent, left-aligned; out already carries the current one
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      sreg      <= '0;
      out       <= 1'b0;
      shifting  <= 1'b0;
      word_done <= 1'b0;
    end else if (accept) begin
      state     <= S_SHIFT;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      sreg      <= {data[WIDTH-2:0], 1'b0};
      out       <= data[WIDTH-1];
      shifting  <= 1'b1;
      word_done <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          if (!last_bit) begin
            bit_cnt   <= bit_cnt + 1'b1;
            out       <= sreg[WIDTH-1];
            sreg      <= {sreg[WIDTH-2:0], 1'b0};
            word_done <= (bit_cnt == BIT_LAST - 1'b1);
          end else begin
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            out       <= 1'b0;
            shifting  <= 1'b0;
            word_done <= 1'b0;
            if (GAP > 0) state <= S_GAP;
            else         state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (!last_gap) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out       <= 1'b0;
          shifting  <= 1'b0;
          word_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ser5_tx.md
# ser5_tx

Parallel-in, serial-out transmitter that feeds the serial input of the 5-bit serial-in/parallel-out shift register stage. It accepts one WIDTH-bit word per valid/ready handshake and drives it onto a single serial line, MSB first, one bit per clock. After the last bit has been clocked into the downstream register, that register holds the word with `data[WIDTH-1]` at output `a` and `data[0]` at output `e`. A programmable idle gap can be inserted between words.

## Interface
- `WIDTH`, default 5: word width in bits, legal range 2..16.
- `GAP`, default 0: idle cycles inserted after each word, legal range 0..7.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  reset, synchronous and active-high. Sampled on the rising edge of `clk`; it has no asynchronous effect.
- `data`  in  WIDTH  parallel word, sampled only at handshake.
- `valid`  in  1  upstream has a word on `data`.
- `ready`  out  1  block can accept a word this cycle.
- `out`  out  1  serial bit; connects to the downstream `in`.
- `shifting`  out  1  high in every cycle in which `out` carries a data bit.
- `word_done`  out  1  one-cycle pulse in the cycle `out` carries `data[0]`.

## Operation
- States:
  - IDLE: `out`=0, `shifting`=0.
  - SHIFT: a bit counter runs 0..WIDTH-1.
  - GAP: a gap counter runs 0..GAP-1.
- Handshake: a word is accepted on a rising edge where `valid`=1, `ready`=1 and `clear`=0. `data` is copied into an internal shift register. Later changes on `data` have no effect on the word in flight.
- `ready` is derived from state. It is 1 in any of these cases:
  - the block is in IDLE;
  - the block is in the last SHIFT cycle and GAP=0;
  - the block is in the last GAP cycle.
- Transitions:
  - IDLE → SHIFT on acceptance.
  - SHIFT on its last bit, when GAP=0: go to SHIFT with a new word if one is accepted, otherwise go to IDLE.
  - SHIFT on its last bit, when GAP>0: go to GAP.
  - GAP on its last cycle: go to SHIFT if a word is accepted, otherwise go to IDLE.
- SHIFT cycle k (k=0..WIDTH-1):
  - `out`=`data[WIDTH-1-k]` and `shifting`=1;
  - `word_done`=1 only at k=WIDTH-1.
- GAP cycles: `out`=0, `shifting`=0, `word_done`=0.
- `out`, `shifting` and `word_done` are registered outputs, glitch-free, and change only after `clk` edges.
- Reset: an edge with `clear`=1 forces the following, from the next cycle on:
  - state IDLE, both counters 0, shift register 0;
  - `out`=0, `shifting`=0, `word_done`=0, `ready`=1.
  - `valid` is ignored while `clear`=1.
- Reset mid-word: the word is aborted and no `word_done` is issued. The downstream register must share the same `clear`, so it does not keep a partial word.
- Simultaneous `clear` and `valid`: `clear` wins and no word is accepted.

## Timing
- Acceptance at edge E0: bit `data[WIDTH-1]` is on `out` in the cycle after E0. Bit k is on `out` during cycle k+1 after E0.
- The downstream register captures bit k at edge E0+k+1. The full word is present at its parallel outputs after edge E0+WIDTH.
- GAP=0 with `valid` held: words stream back-to-back with no bubble. The next word's MSB follows `data[0]` in the very next cycle.
- GAP=g>0: g zero cycles follow each word. The minimum word period is WIDTH+g cycles.
- Throughput: one bit per cycle inside a word. The latency from handshake to first bit is 1 cycle.

## Test plan
- Reset and idle: hold `clear`=1 for 2 edges with `valid`=1, `data`=5'b11111. Required: `out`=0, `shifting`=0, `word_done`=0, `ready`=1 throughout, and no word is sent.
- Single word, GAP=0: send 5'b10110. Required:
  - `out` is 1,0,1,1,0 in cycles 1..5 after acceptance, with `shifting`=1 in those cycles;
  - `word_done` is high in cycle 5 only;
  - the downstream register reads a..e = 1,0,1,1,0 after edge 5.
- Back-to-back, GAP=0: send 5'b10110 then 5'b01001 with `valid` held high. Required:
  - 10 consecutive bits 1011001001 with no bubble;
  - `word_done` in cycles 5 and 10;
  - `ready` is high only in IDLE and in cycles 5 and 10.
- Gap, GAP=2: send two words of 5'b11111. Required:
  - 5 ones, then 2 cycles of `out`=0 with `shifting`=0, then 5 ones;
  - `ready` is high in the 2nd gap cycle.
- Clear mid-word: assert `clear` during bit 3 of 5'b10101. Required:
  - in the next cycle `out`=0, `shifting`=0 and `ready`=1, with no `word_done`;
  - a following word 5'b01110 is then sent complete and correct.
- Data stability: change `data` every cycle while a word 5'b00011 is shifting. Required: `out` is still 0,0,0,1,1, and `data` is re-sampled only at the next handshake.
